// File: rtl/test_basic22_sink_pkg.sv
// Shared types for the test_compound producer/consumer pair: sample struct,
// sink control sections and saturation rails.
package test_basic22_sink_pkg;

  typedef struct packed {
    logic signed [31:0] x;
    logic        [31:0] y;
  } test_compound;

  typedef enum logic {
    SEC_RECV = 1'b0,
    SEC_SEND = 1'b1
  } test_basic22_sink_SECTIONS;

  localparam logic signed [31:0] SAT_X_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_X_MIN = 32'sh8000_0000;
  localparam logic        [31:0] SAT_Y_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/test_basic22_sink_if.sv
// Sample-in / result-out sync-notify bundle of the batch sink.
// master = upstream/downstream environment side, slave = the sink itself.
interface test_basic22_sink_if;
  import test_basic22_sink_pkg::*;

  test_compound m_in;
  logic         m_in_sync;
  logic         m_in_notify;
  test_compound m_res;
  logic         m_res_sync;
  logic         m_res_notify;
  logic [7:0]   batch_cnt;

  modport master (
    output m_in, m_in_sync, m_res_sync,
    input  m_in_notify, m_res, m_res_notify, batch_cnt
  );

  modport slave (
    input  m_in, m_in_sync, m_res_sync,
    output m_in_notify, m_res, m_res_notify, batch_cnt
  );

endinterface

// File: rtl/test_basic22_sink_acc.sv
// Next-sum adder: signed x, unsigned y; purely combinational, no flow control.
// Wraps modulo 2^32 by default, saturates when TEST_BASIC22_SINK_SAT_EN is defined.
module test_basic22_sink_acc
  import test_basic22_sink_pkg::*;
(
  input  logic signed [31:0] sum_x,
  input  logic        [31:0] sum_y,
  input  test_compound       sample,
  output logic signed [31:0] nxt_x,
  output logic        [31:0] nxt_y
);

`ifdef TEST_BASIC22_SINK_SAT_EN
  logic [32:0] add_x;
  logic [32:0] add_y;

  always_comb begin
    add_x = {sum_x[31], sum_x} + {sample.x[31], sample.x};
    add_y = {1'b0, sum_y} + {1'b0, sample.y};
    nxt_x = add_x[31:0];
    // sign bits disagree only when the true sum left the 32-bit signed range
    if (add_x[32] != add_x[31]) begin
      nxt_x = add_x[32] ? SAT_X_MIN : SAT_X_MAX;
    end
    nxt_y = add_y[32] ? SAT_Y_MAX : add_y[31:0];
  end
`else
  always_comb begin
    nxt_x = sum_x + sample.x;
    nxt_y = sum_y + sample.y;
  end
`endif

endmodule

// File: rtl/test_basic22_sink.sv
// Batch sink: sums THRESH samples, then offers {sum_x,sum_y} as one result.
// Result 1 cycle after the last sample edge; input is closed while a result waits.
module test_basic22_sink
  import test_basic22_sink_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic                clk,
  input  logic                rst,
  test_basic22_sink_if.slave  bus
);

  localparam logic [7:0] THRESH_CNT = 8'(THRESH);

  test_basic22_sink_SECTIONS sec_q, sec_d;

  logic signed [31:0] sum_x_q, sum_x_d, acc_x;
  logic        [31:0] sum_y_q, sum_y_d, acc_y;
  logic        [7:0]  cnt_q, cnt_d, cnt_inc;
  test_compound       res_q, res_d;
  logic               in_notify_q, in_notify_d;
  logic               res_notify_q, res_notify_d;
  logic               in_xfer, res_xfer;

  test_basic22_sink_acc u_acc (
    .sum_x  (sum_x_q),
    .sum_y  (sum_y_q),
    .sample (bus.m_in),
    .nxt_x  (acc_x),
    .nxt_y  (acc_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q        <= SEC_RECV;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      in_notify_q  <= 1'b1;
      res_notify_q <= 1'b0;
    end else begin
      sec_q        <= sec_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      in_notify_q  <= in_notify_d;
      res_notify_q <= res_notify_d;
    end
  end

  always_comb begin
    sec_d        = sec_q;
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    in_notify_d  = in_notify_q;
    res_notify_d = res_notify_q;
    cnt_inc      = cnt_q + 8'd1;
    // handshakes qualify only on registered notifies, so sync never reaches an output combinationally
    in_xfer      = bus.m_in_sync && in_notify_q;
    res_xfer     = bus.m_res_sync && res_notify_q;

    case (sec_q)
      SEC_RECV: begin
        if (in_xfer) begin
          sum_x_d = acc_x;
          sum_y_d = acc_y;
          cnt_d   = cnt_inc;
          if (cnt_inc == THRESH_CNT) begin
            res_d.x      = acc_x;
            res_d.y      = acc_y;
            res_notify_d = 1'b1;
            in_notify_d  = 1'b0;
            sec_d        = SEC_SEND;
          end
        end
      end
      SEC_SEND: begin
        // res_q deliberately keeps the delivered result after the transfer
        if (res_xfer) begin
          sum_x_d      = '0;
          sum_y_d      = '0;
          cnt_d        = '0;
          res_notify_d = 1'b0;
          in_notify_d  = 1'b1;
          sec_d        = SEC_RECV;
        end
      end
    endcase
  end

  assign bus.m_in_notify  = in_notify_q;
  assign bus.m_res_notify = res_notify_q;
  assign bus.m_res        = res_q;
  assign bus.batch_cnt    = cnt_q;

endmodule
